// File: rtl/qcore_ctrl_pipe.sv
// qcore_ctrl_pipe: RD/X1/X2/WR control-word sequencer with hold, bubble, flush and stall watchdog.
// Defining QPROC_PIPE_STATS_EN adds stall_id/stall_rd/flush event counters.
module qcore_ctrl_pipe #(
    parameter int CTRL_W    = 12,
    parameter int STALL_MAX = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              halt_i,
    input  logic              flush_i,
    input  logic              bubble_id_i,
    input  logic              bubble_rd_i,
    input  logic              id_vld_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    output logic              id_hold_o,
    output logic              rd_vld_o,
    output logic              x1_vld_o,
    output logic              x2_vld_o,
    output logic              wr_vld_o,
    output logic [CTRL_W-1:0] rd_ctrl_o,
    output logic [CTRL_W-1:0] x1_ctrl_o,
    output logic [CTRL_W-1:0] x2_ctrl_o,
    output logic [CTRL_W-1:0] wr_ctrl_o,
    output logic              pipe_empty_o,
    input  logic              clr_err_i,
`ifdef QPROC_PIPE_STATS_EN
    output logic [31:0]       stall_id_cnt_o,
    output logic [31:0]       stall_rd_cnt_o,
    output logic [31:0]       flush_cnt_o,
`endif
    output logic              stall_err_o
);
    localparam logic [1:0]  RUN    = 2'd0;
    localparam logic [1:0]  STALL  = 2'd1;
    localparam logic [1:0]  HALTED = 2'd2;
    localparam logic [15:0] SMAX   = 16'(STALL_MAX);

    // Each stage holds {valid, ctrl}; a bubble is all-zero.
    logic [CTRL_W:0] rd_q, rd_d, x1_q, x1_d, x2_q, x2_d, wr_q, wr_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [1:0]      mode;

    always_comb begin
        mode  = halt_i ? HALTED : (!flush_i && (bubble_id_i || bubble_rd_i)) ? STALL : RUN;
        rd_d  = rd_q;
        x1_d  = x1_q;
        x2_d  = x2_q;
        wr_d  = wr_q;
        if (!halt_i) begin
            x2_d = x1_q;
            wr_d = x2_q;
            if (flush_i) begin
                rd_d = '0;
                x1_d = '0;
            end else if (bubble_rd_i) begin
                x1_d = '0;
            end else begin
                x1_d = rd_q;
                rd_d = (bubble_id_i || !id_vld_i) ? '0 : {1'b1, id_ctrl_i};
            end
        end
        cnt_d = (mode == HALTED) ? cnt_q :
                (mode == STALL)  ? ((cnt_q == SMAX) ? cnt_q : cnt_q + 16'd1) : 16'd0;
        // Fires only on the edge the counter first reaches the limit; set beats clear.
        err_d = (mode == STALL && cnt_q != SMAX && cnt_q + 16'd1 == SMAX) || (err_q && !clr_err_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            x1_q  <= '0;
            x2_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            x1_q  <= x1_d;
            x2_q  <= x2_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

`ifdef QPROC_PIPE_STATS_EN
    logic [31:0] sid_q, sid_d, srd_q, srd_d, fl_q, fl_d;

    always_comb begin
        sid_d = clr_err_i ? 32'd0 : (mode == STALL && !bubble_rd_i) ? sid_q + 32'd1 : sid_q;
        srd_d = clr_err_i ? 32'd0 : (mode == STALL && bubble_rd_i) ? srd_q + 32'd1 : srd_q;
        fl_d  = clr_err_i ? 32'd0 : (!halt_i && flush_i) ? fl_q + 32'd1 : fl_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sid_q <= '0;
            srd_q <= '0;
            fl_q  <= '0;
        end else begin
            sid_q <= sid_d;
            srd_q <= srd_d;
            fl_q  <= fl_d;
        end
    end

    assign stall_id_cnt_o = sid_q;
    assign stall_rd_cnt_o = srd_q;
    assign flush_cnt_o    = fl_q;
`endif

    assign id_hold_o    = halt_i || (!flush_i && (bubble_id_i || bubble_rd_i));
    assign rd_vld_o     = rd_q[CTRL_W];
    assign x1_vld_o     = x1_q[CTRL_W];
    assign x2_vld_o     = x2_q[CTRL_W];
    assign wr_vld_o     = wr_q[CTRL_W];
    assign rd_ctrl_o    = rd_q[CTRL_W-1:0];
    assign x1_ctrl_o    = x1_q[CTRL_W-1:0];
    assign x2_ctrl_o    = x2_q[CTRL_W-1:0];
    assign wr_ctrl_o    = wr_q[CTRL_W-1:0];
    assign pipe_empty_o = !(rd_q[CTRL_W] || x1_q[CTRL_W] || x2_q[CTRL_W] || wr_q[CTRL_W]);
    assign stall_err_o  = err_q;
endmodule
